mem_bus_if: RTL

Load/store bus interface unit between the CPU datapath and the Avalon memory-mapped master port. Accepts one memory request at a time from the control/datapath side and runs it as a single Avalon read or write, holding it while `waitrequest` is high. Generates byte lanes for SB/SH/SW. Produces sign/zero-extended LB/LBU/LH/LHU/LW data and merged LWL/LWR data. Asserts a stall toward the FSM until the access completes.

---
 rtl/codes_pkg.sv | 55 +++++
 rtl/mem_bus_if_load_align.sv | 43 ++++
 rtl/mem_bus_if.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/codes_pkg.sv
// Shared encodings for the load/store bus unit: access kinds, bus FSM states
// and the request-decoding helpers used by mem_bus_if.
package codes;

    typedef enum logic [2:0] {
        MEM_BYTE = 3'd0,
        MEM_HALF = 3'd1,
        MEM_WORD = 3'd2,
        MEM_WL   = 3'd3,
        MEM_WR   = 3'd4
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } bus_state_t;

    // Misaligned half/word, or a partial-word store (LWL/LWR have no store form here).
    function automatic logic is_bad_access(input mem_size_t size, input logic wen,
                                           input logic [1:0] n);
        logic bad;
        bad = 1'b0;
        case (size)
            MEM_HALF:       bad = n[0];
            MEM_WORD:       bad = (n != 2'b00);
            MEM_WL, MEM_WR: bad = wen;
            default:        bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_enable(input mem_size_t size, input logic [1:0] n);
        logic [3:0] be;
        be = 4'b1111;
        case (size)
            MEM_BYTE: be = 4'b0001 << n;
            MEM_HALF: be = n[1] ? 4'b1100 : 4'b0011;
            default:  be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_data(input mem_size_t size, input logic [31:0] wdata);
        logic [31:0] d;
        d = wdata;
        case (size)
            MEM_BYTE: d = {4{wdata[7:0]}};
            MEM_HALF: d = {2{wdata[15:0]}};
            default:  d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_bus_if_load_align.sv
// Combinational load formatting: byte/half extraction with sign or zero
// extension, and the LWL/LWR merge of the memory word into rt.
module load_align
    import codes::*;
(
    input  logic [31:0] w,
    input  logic [1:0]  n,
    input  mem_size_t   size,
    input  logic        sign,
    input  logic [31:0] rt,
    output logic [31:0] data
);

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic [5:0]  lane_sh_s;
    logic [5:0]  lwl_sh_s;
    logic [5:0]  mask_sh_s;
    logic [31:0] w_down_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Shift amounts are in bits; a 32-bit shift deliberately yields zero.
    assign lane_sh_s = {1'b0, n, 3'b000};
    assign lwl_sh_s  = {1'b0, ~n, 3'b000};
    assign mask_sh_s = lane_sh_s + 6'd8;
    assign w_down_s  = w >> lane_sh_s;
    assign byte_s    = w_down_s[7:0];
    assign half_s    = n[1] ? w[31:16] : w[15:0];

    // Select the formatted result for the access kind.
    always_comb begin
        data = w;
        case (size)
            MEM_BYTE: data = {{24{sign & byte_s[7]}}, byte_s};
            MEM_HALF: data = {{16{sign & half_s[15]}}, half_s};
            MEM_WL:   data = (w << lwl_sh_s) | (rt & (ONES >> mask_sh_s));
            MEM_WR:   data = w_down_s | (rt & ~(ONES >> lane_sh_s));
            default:  data = w;
        endcase
    end

endmodule

// File: rtl/mem_bus_if.sv
// Load/store unit between the core and an Avalon-MM master port: one request
// at a time, held on the bus while waitrequest is high, with a completion pulse.
module mem_bus_if
    import codes::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic        wen_i,
    input  mem_size_t   size_i,
    input  logic        sign_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rt_i,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    bus_state_t  state_q, state_d;
    logic [31:0] address_q, address_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [31:0] writedata_q, writedata_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        wen_q, wen_d;
    mem_size_t   size_q, size_d;
    logic        sign_q, sign_d;
    logic [1:0]  n_q, n_d;
    logic [31:0] rt_q, rt_d;

    logic        bad_s;
    logic [31:0] load_data_s;

    assign bad_s = is_bad_access(size_i, wen_i, addr_i[1:0]);

    load_align u_load_align (
        .w    (readdata),
        .n    (n_q),
        .size (size_q),
        .sign (sign_q),
        .rt   (rt_q),
        .data (load_data_s)
    );

    // Next-state, request latch and bus strobe generation.
    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        read_d       = read_q;
        write_d      = write_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        rdata_d      = rdata_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        wen_d        = wen_q;
        size_d       = size_q;
        sign_d       = sign_q;
        n_d          = n_q;
        rt_d         = rt_q;
        case (state_q)
            IDLE: begin
                if (req_i && bad_s) begin
                    err_d = 1'b1;
                end else if (req_i) begin
                    wen_d        = wen_i;
                    size_d       = size_i;
                    sign_d       = sign_i;
                    n_d          = addr_i[1:0];
                    rt_d         = rt_i;
                    address_d    = {addr_i[31:2], 2'b00};
                    read_d       = ~wen_i;
                    write_d      = wen_i;
                    byteenable_d = lane_enable(size_i, addr_i[1:0]);
                    writedata_d  = lane_data(size_i, wdata_i);
                    state_d      = BUS;
                end else begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                    if (!wen_q) begin
                        rdata_d = load_data_s;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = BUS;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any bus transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            address_q    <= 32'd0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            writedata_q  <= 32'd0;
            byteenable_q <= 4'b0000;
            rdata_q      <= 32'd0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            wen_q        <= 1'b0;
            size_q       <= MEM_BYTE;
            sign_q       <= 1'b0;
            n_q          <= 2'b00;
            rt_q         <= 32'd0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            read_q       <= read_d;
            write_q      <= write_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            rdata_q      <= rdata_d;
            done_q       <= done_d;
            err_q        <= err_d;
            wen_q        <= wen_d;
            size_q       <= size_d;
            sign_q       <= sign_d;
            n_q          <= n_d;
            rt_q         <= rt_d;
        end
    end

    assign stall_o    = ((state_q == IDLE) && req_i && !bad_s) || (state_q == BUS);
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign rdata_o    = rdata_q;
    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;

endmodule
